// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state encoding and stall/flush control vectors for the hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MDU_WAIT   = 2'd2,
      IRQ_DRAIN  = 2'd3
   } state_t;

   typedef struct packed {
      logic stall_if_id;
      logic stall_ex;
      logic stall_mem;
      logic flush_id;
      logic flush_ex;
   } ctrl_t;

   localparam ctrl_t NO_CTRL     = 5'b00000;
   localparam ctrl_t ALL_STALL   = 5'b11111;
   localparam ctrl_t RET_FLUSH   = 5'b11011;
   localparam ctrl_t MISP_FLUSH  = 5'b00010;
   localparam ctrl_t MDU_STALL   = 5'b11000;
   localparam ctrl_t LOAD_BUBBLE = 5'b10001;

endpackage

// File: rtl/hazard_down_counter.sv
// hazard_down_counter: loadable down-counter with zero flag, shared by the load-stall and irq-drain sequences.
module hazard_down_counter #(
   parameter int W = 2
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk_in) begin
      if (rst_in) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (dec && cnt != '0) cnt <= cnt - 1'b1;
   end
   assign zero = (cnt == '0);
endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: decodes load-use, mispredict, MDU and interrupt hazards and sequences
// the stall/flush enables of the IF/ID, ID/EX, EX and MEM pipeline registers.
module hazard_control_unit #(
   parameter int REG_ADDR_W        = 5,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int IRQ_DRAIN_CYCLES  = 2
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [REG_ADDR_W-1:0] rs1_in,
   input  logic [REG_ADDR_W-1:0] rs2_in,
   input  logic                  rs1_used_in,
   input  logic                  rs2_used_in,
   input  logic [REG_ADDR_W-1:0] rd_ID_EX_in,
   input  logic                  read_signal_in,
   input  logic                  branch_jump_signal_in,
   input  logic                  branch_pred_signal_in,
   input  logic                  mdu_start_in,
   input  logic                  mdu_done_in,
   input  logic                  interrupt_signal_in,
   input  logic                  return_interrupt_signal_in,
   output logic                  stall_IF_ID_signal_out,
   output logic                  stall_EX_signal_out,
   output logic                  stall_MEM_signal_out,
   output logic                  flush_ID_signal_out,
   output logic                  flush_EX_signal_out,
   output logic                  irq_ack_out,
   output logic [1:0]            state_out
);
   import hazard_pkg::*;

   localparam int MAX_CYC = (LOAD_STALL_CYCLES > IRQ_DRAIN_CYCLES) ? LOAD_STALL_CYCLES : IRQ_DRAIN_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);
   localparam logic LOAD_MULTI = (LOAD_STALL_CYCLES > 1);
   localparam logic IRQ_MULTI  = (IRQ_DRAIN_CYCLES > 1);
   // The accepting cycle in RUN is the first bubble, so the counter covers only the remaining ones.
   localparam logic [CW-1:0] LOAD_VAL = CW'(LOAD_MULTI ? LOAD_STALL_CYCLES - 2 : 0);
   localparam logic [CW-1:0] IRQ_VAL  = CW'(IRQ_MULTI ? IRQ_DRAIN_CYCLES - 2 : 0);

   state_t          state, nxt;
   ctrl_t           ctrl;
   logic            ack, cnt_load, cnt_dec, cnt_zero, load_use, mispredict;
   logic [CW-1:0]   cnt_val;

   assign load_use   = read_signal_in && rd_ID_EX_in != '0 &&
                       ((rs1_used_in && rs1_in == rd_ID_EX_in) || (rs2_used_in && rs2_in == rd_ID_EX_in));
   assign mispredict = branch_jump_signal_in && !branch_pred_signal_in;

   hazard_down_counter #(.W(CW)) u_cnt (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (cnt_val),
      .zero     (cnt_zero)
   );

   always_comb begin
      ctrl     = NO_CTRL;
      nxt      = state;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_val  = LOAD_VAL;
      ack      = 1'b0;
      if ((state == RUN || state == LOAD_STALL) && interrupt_signal_in) begin
         ctrl     = ALL_STALL;
         nxt      = IRQ_MULTI ? IRQ_DRAIN : RUN;
         cnt_load = 1'b1;
         cnt_val  = IRQ_VAL;
         ack      = !IRQ_MULTI;
      end else begin
         case (state)
            RUN: begin
               if (return_interrupt_signal_in) ctrl = RET_FLUSH;
               else if (mispredict) ctrl = MISP_FLUSH;
               else if (mdu_start_in) begin
                  ctrl = MDU_STALL;
                  nxt  = mdu_done_in ? RUN : MDU_WAIT;
               end else if (load_use) begin
                  ctrl     = LOAD_BUBBLE;
                  nxt      = LOAD_MULTI ? LOAD_STALL : RUN;
                  cnt_load = LOAD_MULTI;
               end
            end
            LOAD_STALL: begin
               ctrl    = LOAD_BUBBLE;
               nxt     = cnt_zero ? RUN : LOAD_STALL;
               cnt_dec = !cnt_zero;
            end
            MDU_WAIT: begin
               ctrl = mdu_done_in ? NO_CTRL : MDU_STALL;
               nxt  = mdu_done_in ? RUN : MDU_WAIT;
            end
            IRQ_DRAIN: begin
               ctrl    = ALL_STALL;
               ack     = cnt_zero;
               nxt     = cnt_zero ? RUN : IRQ_DRAIN;
               cnt_dec = !cnt_zero;
            end
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) state <= RUN;
      else state <= nxt;
   end

   assign {stall_IF_ID_signal_out, stall_EX_signal_out, stall_MEM_signal_out,
           flush_ID_signal_out, flush_EX_signal_out} = rst_in ? NO_CTRL : ctrl;
   assign irq_ack_out = !rst_in && ack;
   assign state_out   = rst_in ? RUN : state;
endmodule
